// File: rtl/reg_bank_param.sv
// Parametrised GPR bank with combinational read ports, optional write bypass,
// a dedicated link register (ra) and a dump sequencer that streams every register.
module reg_bank_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_REGS = 5,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
  output logic [DATA_W-1:0] ra_out,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);

  localparam logic [ADDR_W-1:0] LinkAddr = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] LastReg  = ADDR_W'(NUM_REGS - 1);

  localparam logic StIdle = 1'b0;
  localparam logic StScan = 1'b1;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] ra_q, ra_d;
  logic              state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) || (a == LinkAddr);
  endfunction

  // Storage view only; unmapped addresses read as zero.
  function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) v = regs_q[i];
    end
    if (a == LinkAddr) v = ra_q;
    return v;
  endfunction

  // Link port outranks a general write to ra, so it is checked first.
  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    if (BYPASS && link_en && (a == LinkAddr)) return link_data;
    if (BYPASS && wr_en && is_mapped(wr_addr) && (wr_addr == a)) return wr_data;
    return stored(a);
  endfunction

  assign rd_data1 = rd_port(rd_addr1);
  assign rd_data2 = rd_port(rd_addr2);
  assign ra_out   = ra_q;

  always_comb begin
    regs_d = regs_q;
    ra_d   = ra_q;
    if (wr_en) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == ADDR_W'(i)) regs_d[i] = wr_data;
      end
      if (wr_addr == LinkAddr) ra_d = wr_data;
    end
    if (link_en) ra_d = link_data;
  end

  // Scan walks 0..NUM_REGS-1, then jumps to the link address and stops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == StIdle) begin
      if (dump_start) begin
        state_d = StScan;
        idx_d   = '0;
      end
    end else begin
      if (idx_q == LinkAddr) begin
        state_d = StIdle;
        idx_d   = '0;
      end else if (idx_q == LastReg) begin
        idx_d = LinkAddr;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      ra_q    <= '0;
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      ra_q    <= ra_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign dump_valid = (state_q == StScan);
  assign dump_busy  = dump_valid;
  assign dump_idx   = idx_q;
  assign dump_data  = stored(idx_q);

endmodule

// File: tb/tb_reg_bank_param.sv
// Randomised and directed bench for reg_bank_param against an array-based model;
// a BYPASS=0 instance shares the stimulus to cover the non-bypassed read path.
module tb_reg_bank_param;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 5;
  localparam int LA = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, dump_idx, dump_idx_nb;
  logic [DW-1:0] rd_data1, rd_data2, rd_data1_nb, rd_data2_nb;
  logic [DW-1:0] wr_data, link_data, ra_out, ra_out_nb, dump_data, dump_data_nb;
  logic          wr_en, link_en, dump_start;
  logic          dump_busy, dump_valid, dump_busy_nb, dump_valid_nb;

  always #5 clock = ~clock;

  reg_bank_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .BYPASS(1'b1)) u_dut (
    .clock(clock), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_data(link_data), .ra_out(ra_out),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data)
  );

  reg_bank_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .BYPASS(1'b0)) u_dut_nb (
    .clock(clock), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1_nb), .rd_data2(rd_data2_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_data(link_data), .ra_out(ra_out_nb),
    .dump_start(dump_start), .dump_busy(dump_busy_nb), .dump_valid(dump_valid_nb),
    .dump_idx(dump_idx_nb), .dump_data(dump_data_nb)
  );

  // Reference model: one entry per address, unmapped entries stay zero forever.
  logic [DW-1:0] mem [8];
  bit            m_scan;
  int            m_pos;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mapped(input int a);
    return (a < NR) || (a == LA);
  endfunction

  function automatic logic [DW-1:0] mread(input int a, input bit byp);
    if (byp && link_en && a == LA) return link_data;
    if (byp && wr_en && mapped(int'(wr_addr)) && int'(wr_addr) == a) return wr_data;
    return mem[a];
  endfunction

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    link_en = 1'b0; link_data = '0; dump_start = 1'b0;
  endtask

  // Let combinational outputs settle, then compare everything against the model.
  task automatic settle();
    int ei;
    #1;
    check("rd1", rd_data1, mread(int'(rd_addr1), 1'b1));
    check("rd2", rd_data2, mread(int'(rd_addr2), 1'b1));
    check("rd1_nb", rd_data1_nb, mread(int'(rd_addr1), 1'b0));
    check("rd2_nb", rd_data2_nb, mread(int'(rd_addr2), 1'b0));
    check("ra", ra_out, mem[LA]);
    check("valid", dump_valid, m_scan);
    check("busy", dump_busy, m_scan);
    check("valid_nb", dump_valid_nb, m_scan);
    if (m_scan) begin
      ei = (m_pos < NR) ? m_pos : LA;
      check("dump_idx", dump_idx, ei);
      check("dump_data", dump_data, mem[ei]);
      check("dump_data_nb", dump_data_nb, mem[ei]);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      m_scan = 1'b0;
      m_pos  = 0;
    end else begin
      if (wr_en && mapped(int'(wr_addr))) mem[wr_addr] = wr_data;
      if (link_en) mem[LA] = link_data;
      if (m_scan) begin
        if (m_pos == NR) m_scan = 1'b0;
        else m_pos++;
      end else if (dump_start) begin
        m_scan = 1'b1;
        m_pos  = 0;
      end
    end
    #1;
  endtask

  int            beats;
  logic [AW-1:0] got_idx [8];
  logic [DW-1:0] got_dat [8];
  logic [AW-1:0] exp_idx [6];

  initial begin
    exp_idx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    for (int i = 0; i < 8; i++) mem[i] = '0;
    m_scan = 1'b0; m_pos = 0;
    idle_inputs();
    rd_addr1 = '0; rd_addr2 = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Everything reads zero after reset.
    check("rst_idx", dump_idx, 0);
    for (int a = 0; a < 8; a++) begin
      rd_addr1 = AW'(a); rd_addr2 = AW'(7 - a);
      settle();
      check("rst_rd1", rd_data1, 0);
      check("rst_rd2", rd_data2, 0);
      tick();
    end
    check("rst_ra", ra_out, 0);

    // Mapped write lands, unmapped write is dropped.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hA5; settle(); tick();
    wr_addr = 3'd6; wr_data = 8'h3C; settle(); tick();
    wr_en = 1'b0; rd_addr1 = 3'd2; rd_addr2 = 3'd6; settle();
    check("wr_reg2", rd_data1, 8'hA5);
    check("wr_unmapped", rd_data2, 8'h00);
    tick();

    // Same-cycle bypass vs stored value.
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h7E; rd_addr1 = 3'd1; settle();
    check("bypass", rd_data1, 8'h7E);
    check("no_bypass", rd_data1_nb, 8'h00);
    tick();

    // Link port beats a general write to ra, in storage and in the bypass.
    wr_addr = 3'd7; wr_data = 8'h11; link_en = 1'b1; link_data = 8'h40; rd_addr1 = 3'd7;
    settle();
    check("link_bypass", rd_data1, 8'h40);
    tick();
    idle_inputs();
    check("link_wins", ra_out, 8'h40);

    // Dump: regs 0..4 = 1..5, ra = 0x99; a second start mid-dump is ignored.
    for (int i = 0; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i + 1); settle(); tick();
    end
    idle_inputs(); link_en = 1'b1; link_data = 8'h99; settle(); tick();
    idle_inputs(); dump_start = 1'b1; settle(); tick();
    dump_start = 1'b0;
    beats = 0;
    for (int c = 0; c < 10; c++) begin
      dump_start = (beats == 2);
      settle();
      if (dump_valid) begin
        if (beats < 8) begin got_idx[beats] = dump_idx; got_dat[beats] = dump_data; end
        beats++;
      end
      tick();
    end
    dump_start = 1'b0;
    check("dump_beats", beats, 6);
    for (int i = 0; i < 6; i++) begin
      check("dump_seq_idx", got_idx[i], exp_idx[i]);
      check("dump_seq_data", got_dat[i], (i < NR) ? i + 1 : 32'h99);
    end
    settle();
    check("dump_done", dump_busy, 0);

    // Reset on the third beat aborts the scan and clears storage.
    dump_start = 1'b1; settle(); tick();
    dump_start = 1'b0; settle(); tick();
    settle(); tick();
    check("third_beat", dump_valid, 1);
    reset = 1'b1; settle(); tick();
    reset = 1'b0; settle();
    check("abort_busy", dump_busy, 0);
    check("abort_valid", dump_valid, 0);
    for (int a = 0; a < 8; a++) begin
      rd_addr1 = AW'(a); #1;
      check("abort_rd", rd_data1, 0);
    end

    // Reset beats a write and a dump request in the same cycle.
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h55; dump_start = 1'b1;
    settle(); tick();
    idle_inputs(); rd_addr1 = 3'd3; settle();
    check("rst_vs_wr", rd_data1, 0);
    check("rst_vs_start", dump_busy, 0);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rd_addr1   = AW'($urandom_range(0, 7));
      rd_addr2   = AW'($urandom_range(0, 7));
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = AW'($urandom_range(0, 7));
      wr_data    = DW'($urandom);
      link_en    = ($urandom_range(0, 3) == 0);
      link_data  = DW'($urandom);
      dump_start = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 49) == 0);
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_param.md
# reg_bank_param

Parametrised general-purpose register bank for the nRisc datapath: two asynchronous read ports, one synchronous write port with optional same-cycle write-to-read bypass, and a dedicated link register (ra) with its own write port for jump-and-link. A built-in dump sequencer streams every register plus ra out over a valid-qualified port for bench and debug observation. The block sits between the decode stage (read addresses) and the writeback mux (write data).

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, register address width
- NUM_REGS, 5, general registers at addresses 0..NUM_REGS-1; must satisfy NUM_REGS < 2**ADDR_W
- BYPASS, 1, 1 = a read of the register being written this cycle returns wr_data; 0 = returns the stored value

Ports (reset reset, synchronous, active-high; clock clock):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data, combinational
- rd_data2  out  DATA_W  read port 2 data, combinational
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- link_en  in  1  ra write enable (jump-and-link)
- link_data  in  DATA_W  return address to store in ra
- ra_out  out  DATA_W  current ra contents
- dump_start  in  1  one-cycle request to stream all registers
- dump_busy  out  1  high while the dump is in progress
- dump_valid  out  1  dump_idx/dump_data valid this cycle
- dump_idx  out  ADDR_W  address of the register being dumped
- dump_data  out  DATA_W  stored value of that register

## Operation
- Address map: 0..NUM_REGS-1 are general registers; LINK_ADDR = 2**ADDR_W-1 is ra; every other address is unmapped.
- Read: a mapped address returns the stored value; an unmapped address returns 0.
- Bypass (BYPASS=1): if wr_en=1, wr_addr is mapped, and wr_addr==rd_addrN, then rd_dataN=wr_data. With link_en=1, reads of LINK_ADDR return link_data.
- Write: on the clock edge with wr_en=1, the mapped wr_addr is updated. A write to LINK_ADDR updates ra. Writes to unmapped addresses are dropped.
- Link port: link_en=1 loads ra with link_data. If link_en=1 and a wr_en write to LINK_ADDR occur in the same cycle, link_data wins, and the bypass follows the same priority.
- Reset: all general registers, ra, and the dump FSM are cleared to 0/IDLE. Reset has priority over any write in the same cycle.
- Dump FSM has two states, IDLE and SCAN:
  - IDLE -> SCAN when dump_start=1; dump_idx is loaded with 0.
  - In SCAN: dump_valid=1 and dump_data=stored value at dump_idx. dump_idx steps 0..NUM_REGS-1, then LINK_ADDR.
  - After the LINK_ADDR beat, the FSM returns to IDLE.
  - dump_start is ignored while in SCAN.
- Reset outputs: dump_busy=0, dump_valid=0, dump_idx=0, ra_out=0. rd_data* are 0 for every address until the first write.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 cycle: the value is visible through storage from the edge after wr_en.
- Dump: dump_start sampled at edge N gives the first dump_valid in cycle N+1. There are exactly NUM_REGS+1 consecutive valid beats; dump_busy equals dump_valid.
- A write committed at edge K is reflected in any dump beat occurring after edge K. The dump does not show bypass values.
- Reset asserted during SCAN: at that edge the FSM returns to IDLE and dump_valid=0 in the following cycle.
- dump_start asserted in the same cycle as reset is ignored.

## Test plan
- Reset, then read all 8 addresses -> every rd_data is 0 and ra_out=0.
- Write 0xA5 to reg 2, then 0x3C to reg 6 (unmapped) -> the next cycle reads 0xA5 from reg 2 and 0 from reg 6.
- BYPASS=1, wr_en with wr_addr=1, wr_data=0x7E, rd_addr1=1 in the same cycle -> rd_data1=0x7E before the edge. BYPASS=0 -> rd_data1 shows the old value.
- Same cycle: link_en with link_data=0x40 and wr_en to address 7 with 0x11 -> ra_out=0x40 after the edge.
- Load regs 0..4 with 1..5 and ra with 0x99, pulse dump_start -> 6 valid beats with idx 0,1,2,3,4,7 and data 1,2,3,4,5,0x99; busy then falls. A second dump_start during the dump is ignored.
- Assert reset during the third dump beat -> next cycle busy=0, valid=0, and all registers read 0. Write and reset in the same cycle -> the register stays 0.
